// File: rtl/nbody_update_scheduler.sv
// Three-body physics update sequencer: time-shares one pair-force unit over AB/AC/BC,
// then commits velocity and position. Optional macro VEL_SAT_EN clamps velocities to +/-VMAX.
//
// state | meaning
// IDLE  | waiting for frame_start (or step while paused)
// PAIR  | requesting force for pair force_sel, accumulating on ack
// VEL   | v += a on frames where frame_cnt mod VEL_DIV == 0
// POS   | p += v (new velocity)
// DONE  | positions visible, update_done pulse, frame_cnt++
module nbody_update_scheduler #(
  parameter int VEL_DIV = 8,
  parameter int VMAX    = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        pause,
  input  logic        step,
  output logic        force_req,
  output logic [1:0]  force_sel,
  output logic [9:0]  force_p0_x,
  output logic [9:0]  force_p0_y,
  output logic [9:0]  force_p1_x,
  output logic [9:0]  force_p1_y,
  input  logic        force_ack,
  input  logic [3:0]  force_fx,
  input  logic [3:0]  force_fy,
  output logic [29:0] pos_x,
  output logic [29:0] pos_y,
  output logic        busy,
  output logic        update_done,
  output logic        overrun,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [2:0] {IDLE, PAIR, VEL, POS, DONE} state_t;

`ifdef VEL_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  localparam logic signed [10:0] V_HI = 11'(VMAX);
  localparam logic signed [10:0] V_LO = -11'(VMAX);
  localparam logic [7:0] DIV_MASK = 8'(VEL_DIV - 1);

  state_t state, state_nxt;
  logic signed [9:0] px [3];
  logic signed [9:0] py [3];
  logic signed [9:0] vx [3];
  logic signed [9:0] vy [3];
  logic signed [5:0] ax [3];
  logic signed [5:0] ay [3];
  logic [1:0] sel;
  logic [7:0] cnt;
  logic       ovr;
  logic       trigger;
  logic       vel_en;
  logic signed [5:0] fx6, fy6;

  assign trigger = (frame_start && !pause) || (step && pause);
  assign vel_en  = (cnt & DIV_MASK) == 8'd0;
  assign fx6     = {{2{force_fx[3]}}, force_fx};
  assign fy6     = {{2{force_fy[3]}}, force_fy};

  function automatic logic signed [9:0] vel_sum(input logic signed [9:0] v,
                                                input logic signed [5:0] a);
    logic signed [10:0] s;
    s = 11'(v) + 11'(a);
    if (SAT_EN && s > V_HI) return 10'(V_HI);
    if (SAT_EN && s < V_LO) return 10'(V_LO);
    return s[9:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    force_req   = 1'b0;
    update_done = 1'b0;
    case (state)
      IDLE: if (trigger) state_nxt = PAIR;
      PAIR: begin
        force_req = 1'b1;
        if (force_ack && sel == 2'd2) state_nxt = VEL;
      end
      VEL:  state_nxt = POS;
      POS:  state_nxt = DONE;
      DONE: begin
        update_done = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      px[0] <= 10'sd270; py[0] <= 10'sd200;
      px[1] <= 10'sd370; py[1] <= 10'sd280;
      px[2] <= 10'sd320; py[2] <= 10'sd160;
      for (int i = 0; i < 3; i++) begin
        vx[i] <= '0; vy[i] <= '0;
        ax[i] <= '0; ay[i] <= '0;
      end
      sel <= 2'd0;
      cnt <= 8'd0;
      ovr <= 1'b0;
    end else begin
      if (busy && (frame_start || step)) ovr <= 1'b1;
      case (state)
        IDLE: if (trigger) begin
          sel <= 2'd0;
          for (int i = 0; i < 3; i++) begin
            ax[i] <= '0; ay[i] <= '0;
          end
        end
        PAIR: if (force_ack) begin
          // first body of the pair gets +f, second gets -f
          case (sel)
            2'd0: begin
              ax[0] <= ax[0] + fx6; ay[0] <= ay[0] + fy6;
              ax[1] <= ax[1] - fx6; ay[1] <= ay[1] - fy6;
            end
            2'd1: begin
              ax[0] <= ax[0] + fx6; ay[0] <= ay[0] + fy6;
              ax[2] <= ax[2] - fx6; ay[2] <= ay[2] - fy6;
            end
            default: begin
              ax[1] <= ax[1] + fx6; ay[1] <= ay[1] + fy6;
              ax[2] <= ax[2] - fx6; ay[2] <= ay[2] - fy6;
            end
          endcase
          if (sel != 2'd2) sel <= sel + 2'd1;
        end
        VEL: if (vel_en) begin
          for (int i = 0; i < 3; i++) begin
            vx[i] <= vel_sum(vx[i], ax[i]);
            vy[i] <= vel_sum(vy[i], ay[i]);
          end
        end
        POS: begin
          for (int i = 0; i < 3; i++) begin
            px[i] <= px[i] + vx[i];
            py[i] <= py[i] + vy[i];
          end
        end
        DONE: cnt <= cnt + 8'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    force_p0_x = px[0]; force_p0_y = py[0];
    force_p1_x = px[1]; force_p1_y = py[1];
    case (sel)
      2'd0: ;
      2'd1: begin
        force_p1_x = px[2]; force_p1_y = py[2];
      end
      default: begin
        force_p0_x = px[1]; force_p0_y = py[1];
        force_p1_x = px[2]; force_p1_y = py[2];
      end
    endcase
  end

  assign force_sel = sel;
  assign busy      = (state != IDLE);
  assign overrun   = ovr;
  assign frame_cnt = cnt;
  assign pos_x     = {px[2], px[1], px[0]};
  assign pos_y     = {py[2], py[1], py[0]};

endmodule
